// File: rtl/nios_sys_pio_keypad_in.sv
// Avalon-MM input PIO for the keypad: 2-FF synchronizer, optional debounce
// (KEYPAD_DEBOUNCE_EN), sticky rising-edge capture and a maskable level irq.
module nios_sys_pio_keypad_in #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 60000,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] data_in_q, data_in_d;
  logic [WIDTH-1:0] data_in_dly_q, data_in_dly_d;
  logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
  logic             wr_en;
  logic             unused_wdata;

  assign wr_en        = chipselect & ~write_n;
  assign unused_wdata = ^writedata;

`ifdef KEYPAD_DEBOUNCE_EN
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Any change of the synchronized bus restarts the stability window.
  always_comb begin
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    data_in_d = data_in_q;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = CNT_W'(DEBOUNCE_CYCLES - 1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else begin
      data_in_d = cand_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cand_q <= '0;
      cnt_q  <= '0;
    end else begin
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
    end
  end
`else
  logic [CNT_W-1:0] unused_cfg;

  assign unused_cfg = CNT_W'(DEBOUNCE_CYCLES);

  always_comb begin
    data_in_d = sync2_q;
  end
`endif

  // Capture set is applied after the write-1-clear so a simultaneous set wins.
  always_comb begin
    sync1_d       = in_port;
    sync2_d       = sync1_q;
    data_in_dly_d = data_in_q;
    irq_mask_d    = irq_mask_q;
    edge_cap_d    = edge_cap_q;
    if (wr_en && address == 2'd2) begin
      irq_mask_d = writedata[WIDTH-1:0];
    end
    if (wr_en && address == 2'd3) begin
      edge_cap_d = edge_cap_q & ~writedata[WIDTH-1:0];
    end
    edge_cap_d = edge_cap_d | (data_in_q & ~data_in_dly_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      data_in_q     <= '0;
      data_in_dly_q <= '0;
      irq_mask_q    <= '0;
      edge_cap_q    <= '0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      data_in_q     <= data_in_d;
      data_in_dly_q <= data_in_dly_d;
      irq_mask_q    <= irq_mask_d;
      edge_cap_q    <= edge_cap_d;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      2'd0:    readdata[WIDTH-1:0] = data_in_q;
      2'd2:    readdata[WIDTH-1:0] = irq_mask_q;
      2'd3:    readdata[WIDTH-1:0] = edge_cap_q;
      default: readdata = '0;
    endcase
  end

  assign irq = |(edge_cap_q & irq_mask_q);

endmodule

// File: tb/tb_nios_sys_pio_keypad_in.sv
// Directed self-checking bench for nios_sys_pio_keypad_in; expectations
// follow KEYPAD_DEBOUNCE_EN so either build can be checked.
module tb_nios_sys_pio_keypad_in;

  localparam int WIDTH = 4;
  localparam int DEB   = 4;
  localparam int CNT_W = 3;
`ifdef KEYPAD_DEBOUNCE_EN
  localparam int  LAT     = DEB + 3;
  localparam bit  DEB_ON  = 1'b1;
`else
  localparam int  LAT     = 3;
  localparam bit  DEB_ON  = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [1:0]       address = 2'd0;
  logic             chipselect = 1'b0;
  logic             write_n = 1'b1;
  logic [31:0]      writedata = 32'd0;
  logic [WIDTH-1:0] in_port = '0;
  logic [31:0]      readdata;
  logic             irq;

  int n_checks = 0;
  int n_fail   = 0;

  nios_sys_pio_keypad_in #(
    .WIDTH(WIDTH),
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .in_port(in_port),
    .readdata(readdata),
    .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic readCheck(input string tag, input logic [1:0] a, input logic [31:0] exp);
    address    = a;
    chipselect = 1'b1;
    #1;
    checkOutput(tag, readdata, exp);
    chipselect = 1'b0;
  endtask

  // One write cycle; returns 1 time unit after the capturing edge.
  task automatic applyStimulus(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  initial begin
    $display("[TB] start, debounce %0d, latency %0d", DEB_ON, LAT);
    tick(3);
    readCheck("rst_data", 2'd0, 32'h0);
    readCheck("rst_mask", 2'd2, 32'h0);
    readCheck("rst_edge", 2'd3, 32'h0);
    checkOutput("rst_irq", {31'd0, irq}, 32'h0);
    reset_n = 1'b1;
    tick(2);

    // Toggle bit 0 every 2 clocks for 20 clocks, then settle at 0.
    for (int i = 0; i < 10; i++) begin
      in_port = (i % 2 == 0) ? 4'h1 : 4'h0;
      tick(2);
    end
    in_port = 4'h0;
    tick(LAT + 3);
    readCheck("toggle_data", 2'd0, 32'h0);
    readCheck("toggle_edge", 2'd3, DEB_ON ? 32'h0 : 32'h1);
    applyStimulus(2'd3, 32'hF);
    readCheck("toggle_clr", 2'd3, 32'h0);

    // Held change 0x0 -> 0x5: exact latency and capture one clock later.
    in_port = 4'h5;
    tick(LAT - 1);
    readCheck("lat_before", 2'd0, 32'h0);
    tick(1);
    readCheck("lat_exact", 2'd0, 32'h5);
    readCheck("edge_not_yet", 2'd3, 32'h0);
    tick(1);
    readCheck("edge_set", 2'd3, 32'h5);
    checkOutput("irq_masked", {31'd0, irq}, 32'h0);

    // Mask / clear behaviour.
    applyStimulus(2'd2, 32'h1);
    readCheck("mask_rd", 2'd2, 32'h1);
    checkOutput("irq_on", {31'd0, irq}, 32'h1);
    applyStimulus(2'd3, 32'h1);
    readCheck("w1c_bit0", 2'd3, 32'h4);
    checkOutput("irq_off", {31'd0, irq}, 32'h0);
    applyStimulus(2'd3, 32'h0);
    readCheck("w0_keep", 2'd3, 32'h4);
    applyStimulus(2'd2, 32'hFFFF_FFF4);
    readCheck("mask_upper", 2'd2, 32'h4);
    checkOutput("irq_mask4", {31'd0, irq}, 32'h1);
    applyStimulus(2'd2, 32'h0);
    checkOutput("irq_unmask", {31'd0, irq}, 32'h0);
    readCheck("edge_kept", 2'd3, 32'h4);
    applyStimulus(2'd0, 32'hF);
    readCheck("data_ro", 2'd0, 32'h5);
    applyStimulus(2'd1, 32'hF);
    readCheck("rsvd_rd", 2'd1, 32'h0);
    applyStimulus(2'd3, 32'hF);
    readCheck("w1c_all", 2'd3, 32'h0);

    // 0x5 -> 0xD: clear bit 3 on the very edge it gets set; set wins.
    in_port = 4'hD;
    tick(LAT);
    readCheck("data_d", 2'd0, 32'hD);
    applyStimulus(2'd3, 32'h8);
    readCheck("set_wins", 2'd3, 32'h8);
    applyStimulus(2'd3, 32'h8);
    readCheck("clr_after", 2'd3, 32'h0);

    // One-clock glitch on bit 1.
    applyStimulus(2'd2, 32'h2);
    in_port = 4'hF;
    tick(1);
    in_port = 4'hD;
    tick(LAT - 1);
    readCheck("glitch_data", 2'd0, DEB_ON ? 32'hD : 32'hF);
    tick(LAT + 2);
    readCheck("glitch_settle", 2'd0, 32'hD);
    readCheck("glitch_edge", 2'd3, DEB_ON ? 32'h0 : 32'h2);
    checkOutput("glitch_irq", {31'd0, irq}, DEB_ON ? 32'h0 : 32'h1);

    // Reset in the middle of a pending change, then static input after release.
    in_port = 4'h3;
    tick(3);
    reset_n = 1'b0;
    #1;
    readCheck("mid_rst_data", 2'd0, 32'h0);
    readCheck("mid_rst_edge", 2'd3, 32'h0);
    readCheck("mid_rst_mask", 2'd2, 32'h0);
    checkOutput("mid_rst_irq", {31'd0, irq}, 32'h0);
    tick(2);
    reset_n = 1'b1;
    tick(LAT - 1);
    readCheck("rel_before", 2'd0, 32'h0);
    tick(1);
    readCheck("rel_exact", 2'd0, 32'h3);
    tick(1);
    readCheck("rel_edge", 2'd3, 32'h3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
